// File: rtl/weight_buffer_pingpong_ctrl.sv
// Ping-pong weight buffer sequencer: a loader fills one half from DDR beats while
// a reader streams the other half to the PE array, interlocked by per-half full flags.
module weight_buffer_pingpong_ctrl #(
    parameter int WRITE_WIDTH    = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY_B = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_start,
    input  logic [ADDR_WIDTH-1:0]  ld_num_words,
    input  logic                   ld_data_valid,
    input  logic [WRITE_WIDTH-1:0] ld_data,
    output logic                   ld_data_ready,
    output logic                   ld_done,
    input  logic                   rd_start,
    input  logic [ADDR_WIDTH-1:0]  rd_num_words,
    input  logic                   rd_stall,
    output logic                   rd_data_valid,
    output logic                   rd_data_last,
    output logic                   rd_done,
    output logic                   bs_write_req,
    output logic [ADDR_WIDTH-1:0]  bs_write_addr,
    output logic [WRITE_WIDTH-1:0] bs_write_data,
    output logic                   bs_read_req,
    output logic [ADDR_WIDTH-1:0]  bs_read_addr,
    output logic [1:0]             half_full
);

    localparam int HALF_AW = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WAIT,
        LD_LOAD
    } ld_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_READ,
        RD_DRAIN
    } rd_state_t;

    ld_state_t                   ld_state, ld_state_nxt;
    logic      [HALF_AW-1:0]     ld_cnt;
    logic      [ADDR_WIDTH-1:0]  ld_last;
    logic                        wr_half;
    logic                        ld_done_q;
    logic                        ld_go;
    logic                        ld_accept;
    logic                        ld_final;

    rd_state_t                   rd_state, rd_state_nxt;
    logic      [HALF_AW-1:0]     rd_cnt;
    logic      [ADDR_WIDTH-1:0]  rd_last;
    logic                        rd_half;
    logic                        rd_done_q;
    logic                        rd_go;
    logic                        rd_issue;
    logic                        rd_issue_last;
    logic                        rd_release;
    logic [READ_LATENCY_B-1:0]   vld_sr;
    logic [READ_LATENCY_B-1:0]   last_sr;

    logic [1:0]                  half_full_q;
    logic [1:0]                  hf_set;
    logic [1:0]                  hf_clr;

    // ---------------- loader ----------------
    assign ld_go = (ld_state == LD_IDLE) && ld_start && (ld_num_words != '0);

    always_comb begin
        ld_state_nxt  = ld_state;
        ld_data_ready = 1'b0;
        ld_accept     = 1'b0;
        ld_final      = 1'b0;
        case (ld_state)
            LD_IDLE: begin
                if (ld_go) ld_state_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                if (!half_full_q[wr_half]) ld_state_nxt = LD_LOAD;
            end
            LD_LOAD: begin
                ld_data_ready = 1'b1;
                ld_accept     = ld_data_valid;
                if (ld_data_valid && (ADDR_WIDTH'(ld_cnt) == ld_last)) begin
                    ld_final     = 1'b1;
                    ld_state_nxt = LD_IDLE;
                end
            end
            default: ld_state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state  <= LD_IDLE;
            ld_cnt    <= '0;
            ld_last   <= '0;
            wr_half   <= 1'b0;
            ld_done_q <= 1'b0;
        end else begin
            ld_state  <= ld_state_nxt;
            ld_done_q <= ld_final;
            if (ld_go) begin
                ld_last <= ld_num_words - ADDR_WIDTH'(1);
                ld_cnt  <= '0;
            end
            if (ld_accept) begin
                ld_cnt <= ld_final ? '0 : ld_cnt + HALF_AW'(1);
                if (ld_final) wr_half <= ~wr_half;
            end
        end
    end

    assign bs_write_req  = ld_accept;
    assign bs_write_addr = ld_accept ? {wr_half, ld_cnt} : '0;
    assign bs_write_data = ld_accept ? ld_data : '0;
    assign ld_done       = ld_done_q;

    // ---------------- reader ----------------
    assign rd_go = (rd_state == RD_IDLE) && rd_start && (rd_num_words != '0);

    always_comb begin
        rd_state_nxt  = rd_state;
        rd_issue      = 1'b0;
        rd_issue_last = 1'b0;
        rd_release    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (rd_go) rd_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (half_full_q[rd_half]) rd_state_nxt = RD_READ;
            end
            RD_READ: begin
                if (!rd_stall) begin
                    rd_issue = 1'b1;
                    if (ADDR_WIDTH'(rd_cnt) == rd_last) begin
                        rd_issue_last = 1'b1;
                        rd_state_nxt  = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                // Leave once the final word's valid emerges from the latency pipe.
                if (last_sr[READ_LATENCY_B-1]) begin
                    rd_release   = 1'b1;
                    rd_state_nxt = RD_IDLE;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state  <= RD_IDLE;
            rd_cnt    <= '0;
            rd_last   <= '0;
            rd_half   <= 1'b0;
            rd_done_q <= 1'b0;
            vld_sr    <= '0;
            last_sr   <= '0;
        end else begin
            rd_state  <= rd_state_nxt;
            rd_done_q <= rd_release;
            if (rd_go) begin
                rd_last <= rd_num_words - ADDR_WIDTH'(1);
                rd_cnt  <= '0;
            end
            if (rd_issue) rd_cnt <= rd_issue_last ? '0 : rd_cnt + HALF_AW'(1);
            if (rd_release) rd_half <= ~rd_half;
            vld_sr[0]  <= rd_issue;
            last_sr[0] <= rd_issue_last;
            for (int unsigned i = 1; i < READ_LATENCY_B; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign bs_read_req   = rd_issue;
    assign bs_read_addr  = rd_issue ? {rd_half, rd_cnt} : '0;
    assign rd_data_valid = vld_sr[READ_LATENCY_B-1];
    assign rd_data_last  = last_sr[READ_LATENCY_B-1];
    assign rd_done       = rd_done_q;

    // ---------------- half flags ----------------
    // Set and clear always address different halves, so both apply together.
    always_comb begin
        hf_set          = '0;
        hf_clr          = '0;
        hf_set[wr_half] = ld_final;
        hf_clr[rd_half] = rd_release;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_full_q <= '0;
        end else begin
            half_full_q <= (half_full_q | hf_set) & ~hf_clr;
        end
    end

    assign half_full = half_full_q;

endmodule

// File: tb/tb_weight_buffer_pingpong_ctrl.sv
// Directed bench for weight_buffer_pingpong_ctrl: loads, reads, stalls, overlap,
// parking on a full half and mid-load reset, with hand-derived expectations.
module tb_weight_buffer_pingpong_ctrl;

    logic       clk;
    logic       reset;
    logic       ld_start;
    logic [7:0] ld_num_words;
    logic       ld_data_valid;
    logic [7:0] ld_data;
    logic       ld_data_ready;
    logic       ld_done;
    logic       rd_start;
    logic [7:0] rd_num_words;
    logic       rd_stall;
    logic       rd_data_valid;
    logic       rd_data_last;
    logic       rd_done;
    logic       bs_write_req;
    logic [7:0] bs_write_addr;
    logic [7:0] bs_write_data;
    logic       bs_read_req;
    logic [7:0] bs_read_addr;
    logic [1:0] half_full;

    int vectors;
    int miscompares;

    weight_buffer_pingpong_ctrl #(
        .WRITE_WIDTH   (8),
        .ADDR_WIDTH    (8),
        .READ_LATENCY_B(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_start     (ld_start),
        .ld_num_words (ld_num_words),
        .ld_data_valid(ld_data_valid),
        .ld_data      (ld_data),
        .ld_data_ready(ld_data_ready),
        .ld_done      (ld_done),
        .rd_start     (rd_start),
        .rd_num_words (rd_num_words),
        .rd_stall     (rd_stall),
        .rd_data_valid(rd_data_valid),
        .rd_data_last (rd_data_last),
        .rd_done      (rd_done),
        .bs_write_req (bs_write_req),
        .bs_write_addr(bs_write_addr),
        .bs_write_data(bs_write_data),
        .bs_read_req  (bs_read_req),
        .bs_read_addr (bs_read_addr),
        .half_full    (half_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read and write must never touch the same half in one cycle.
    always begin
        @(negedge clk);
        #2;
        if (bs_write_req === 1'b1 && bs_read_req === 1'b1) begin
            vectors++;
            if (bs_write_addr[7] === bs_read_addr[7]) begin
                $display("FAIL half_collision: write addr %0h read addr %0h required different halves",
                         bs_write_addr, bs_read_addr);
                miscompares++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic do_load(input int num, input logic [7:0] d0, input logic [7:0] base,
                           input int exp_wait, input string tag);
        int waited;
        ld_start     = 1'b1;
        ld_num_words = 8'(num);
        @(negedge clk);
        ld_start     = 1'b0;
        ld_num_words = '0;
        #1;
        waited = 1;
        while (ld_data_ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (ld_data_ready !== 1'b1) begin
            $display("FAIL %s_ready_timeout: ld_data_ready=%b required 1", tag, ld_data_ready);
            miscompares++;
            return;
        end
        if (exp_wait >= 0) begin
            vectors++;
            if (waited != exp_wait) begin
                $display("FAIL %s_wait: ready after %0d cycles required %0d", tag, waited, exp_wait);
                miscompares++;
            end
        end
        for (int i = 0; i < num; i++) begin
            ld_data_valid = 1'b1;
            ld_data       = 8'(d0 + i);
            #1;
            vectors++;
            if (bs_write_req !== 1'b1 || bs_write_addr !== 8'(base + i) ||
                bs_write_data !== 8'(d0 + i) || ld_done !== 1'b0) begin
                $display("FAIL %s_beat%0d: req=%b addr=%0h data=%0h done=%b required 1 %0h %0h 0",
                         tag, i, bs_write_req, bs_write_addr, bs_write_data, ld_done,
                         8'(base + i), 8'(d0 + i));
                miscompares++;
            end
            @(negedge clk);
            #1;
        end
        ld_data_valid = 1'b0;
        #1;
        vectors++;
        if (ld_done !== 1'b1 || ld_data_ready !== 1'b0 || bs_write_req !== 1'b0) begin
            $display("FAIL %s_done: done=%b ready=%b wreq=%b required 1 0 0",
                     tag, ld_done, ld_data_ready, bs_write_req);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ld_done !== 1'b0) begin
            $display("FAIL %s_done_width: ld_done=%b required 0", tag, ld_done);
            miscompares++;
        end
    endtask

    task automatic do_read(input int num, input logic [7:0] base, input int stall_at,
                           input int stall_len, input int exp_wait, input string tag);
        int waited, issued, nvalid, stalled;
        bit started, stall, exp_req, exp_v, exp_l, finished;
        rd_start     = 1'b1;
        rd_num_words = 8'(num);
        @(negedge clk);
        rd_start     = 1'b0;
        rd_num_words = '0;
        waited = 1; issued = 0; nvalid = 0; stalled = 0;
        started = 0; exp_v = 0; exp_l = 0; finished = 0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            stall    = started && issued == stall_at && stalled < stall_len && issued < num;
            rd_stall = stall;
            #1;
            vectors++;
            if (rd_data_valid !== exp_v || rd_data_last !== exp_l) begin
                $display("FAIL %s_valid: valid=%b last=%b required %b %b",
                         tag, rd_data_valid, rd_data_last, exp_v, exp_l);
                miscompares++;
            end
            if (rd_data_valid === 1'b1) nvalid++;
            if (exp_l) finished = 1;
            if (!started && bs_read_req === 1'b1) begin
                started = 1;
                if (exp_wait >= 0) begin
                    vectors++;
                    if (waited != exp_wait) begin
                        $display("FAIL %s_wait: first issue after %0d cycles required %0d",
                                 tag, waited, exp_wait);
                        miscompares++;
                    end
                end
            end
            exp_req = started && issued < num && !stall;
            if (started) begin
                vectors++;
                if (bs_read_req !== exp_req || (exp_req && bs_read_addr !== 8'(base + issued))) begin
                    $display("FAIL %s_issue%0d: req=%b addr=%0h required %b %0h",
                             tag, issued, bs_read_req, bs_read_addr, exp_req, 8'(base + issued));
                    miscompares++;
                end
            end
            exp_v = exp_req;
            exp_l = exp_req && issued == num - 1;
            if (exp_req) issued++;
            if (stall) stalled++;
            if (!started) waited++;
            if (!finished) @(negedge clk);
        end
        rd_stall = 1'b0;
        vectors++;
        if (!finished) begin
            $display("FAIL %s_timeout: issued %0d required %0d", tag, issued, num);
            miscompares++;
            return;
        end
        vectors++;
        if (nvalid != num) begin
            $display("FAIL %s_count: %0d valids required %0d", tag, nvalid, num);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rd_done !== 1'b1 || rd_data_valid !== 1'b0) begin
            $display("FAIL %s_done: done=%b valid=%b required 1 0", tag, rd_done, rd_data_valid);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rd_done !== 1'b0) begin
            $display("FAIL %s_done_width: rd_done=%b required 0", tag, rd_done);
            miscompares++;
        end
    endtask

    task automatic check_half_full(input logic [1:0] exp, input string tag);
        vectors++;
        if (half_full !== exp) begin
            $display("FAIL %s_half_full: %b required %b", tag, half_full, exp);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({ld_data_ready, ld_done, rd_data_valid, rd_data_last, rd_done, bs_write_req,
             bs_read_req} !== 7'b0 || bs_write_addr !== 8'h00 || bs_write_data !== 8'h00 ||
            bs_read_addr !== 8'h00 || half_full !== 2'b00) begin
            $display("FAIL reset_outputs: flags=%b waddr=%0h wdata=%0h raddr=%0h hf=%b required all 0",
                     {ld_data_ready, ld_done, rd_data_valid, rd_data_last, rd_done, bs_write_req,
                      bs_read_req}, bs_write_addr, bs_write_data, bs_read_addr, half_full);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_basic();
        do_load(4, 8'hA1, 8'h00, 2, "ld_basic");
        check_half_full(2'b01, "ld_basic");
    endtask

    task automatic test_read_basic();
        do_read(4, 8'h00, 0, 0, 2, "rd_basic");
        check_half_full(2'b00, "rd_basic");
    endtask

    task automatic test_full_halves();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_load(128, 8'h00, 8'h00, 2, "fill_h0");
        check_half_full(2'b01, "fill_h0");
        do_load(128, 8'h80, 8'h80, 2, "fill_h1");
        check_half_full(2'b11, "fill_h1");
    endtask

    task automatic test_park();
        int t_done, t_ready, nreq;
        bit seen;
        ld_start     = 1'b1;
        ld_num_words = 8'd4;
        @(negedge clk);
        ld_start     = 1'b0;
        #1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ld_data_ready !== 1'b0) seen = 1;
            @(negedge clk);
            #1;
        end
        vectors++;
        if (seen) begin
            $display("FAIL park_ready: ld_data_ready rose while both halves full, required 0");
            miscompares++;
        end
        rd_start     = 1'b1;
        rd_num_words = 8'd128;
        @(negedge clk);
        rd_start     = 1'b0;
        #1;
        t_done = -1; t_ready = -1; nreq = 0;
        for (int cyc = 0; cyc < 600 && t_ready < 0; cyc++) begin
            if (bs_read_req === 1'b1) begin
                vectors++;
                if (bs_read_addr !== 8'(nreq)) begin
                    $display("FAIL park_raddr: %0h required %0h", bs_read_addr, 8'(nreq));
                    miscompares++;
                end
                nreq++;
            end
            if (rd_done === 1'b1 && t_done < 0) t_done = cyc;
            if (ld_data_ready === 1'b1 && t_ready < 0) t_ready = cyc;
            if (t_ready < 0) begin
                @(negedge clk);
                #1;
            end
        end
        vectors++;
        if (nreq != 128 || t_done < 0 || t_ready != t_done + 1) begin
            $display("FAIL park_release: reads=%0d rd_done@%0d ready@%0d required 128 and ready one cycle after done",
                     nreq, t_done, t_ready);
            miscompares++;
        end
        for (int i = 0; i < 4; i++) begin
            ld_data_valid = 1'b1;
            ld_data       = 8'(8'hC0 + i);
            #1;
            vectors++;
            if (bs_write_req !== 1'b1 || bs_write_addr !== 8'(i)) begin
                $display("FAIL park_beat%0d: req=%b addr=%0h required 1 %0h",
                         i, bs_write_req, bs_write_addr, 8'(i));
                miscompares++;
            end
            @(negedge clk);
            #1;
        end
        ld_data_valid = 1'b0;
        #1;
        vectors++;
        if (ld_done !== 1'b1) begin
            $display("FAIL park_done: ld_done=%b required 1", ld_done);
            miscompares++;
        end
        check_half_full(2'b11, "park");
        @(negedge clk);
    endtask

    task automatic test_stall();
        do_read(8, 8'h80, 3, 3, 2, "rd_stall");
        check_half_full(2'b01, "rd_stall");
    endtask

    task automatic test_back_to_back();
        fork
            do_read(4, 8'h00, 0, 0, 2, "ovl_rd");
            do_load(5, 8'hB0, 8'h80, 2, "ovl_ld");
        join
        check_half_full(2'b10, "overlap");
    endtask

    task automatic test_zero_count();
        bit seen;
        ld_start = 1'b1; ld_num_words = 8'd0;
        rd_start = 1'b1; rd_num_words = 8'd0;
        @(negedge clk);
        ld_start = 1'b0; rd_start = 1'b0;
        #1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ld_data_ready !== 1'b0 || bs_read_req !== 1'b0) seen = 1;
            @(negedge clk);
            #1;
        end
        vectors++;
        if (seen) begin
            $display("FAIL zero_count: zero-length start produced ready/read activity, required none");
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_load();
        int waited;
        ld_start     = 1'b1;
        ld_num_words = 8'd4;
        @(negedge clk);
        ld_start = 1'b0;
        #1;
        waited = 1;
        while (ld_data_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        for (int i = 0; i < 2; i++) begin
            ld_data_valid = 1'b1;
            ld_data       = 8'(8'hD0 + i);
            #1;
            vectors++;
            if (bs_write_req !== 1'b1 || bs_write_addr !== 8'(i)) begin
                $display("FAIL rst_mid_beat%0d: req=%b addr=%0h required 1 %0h",
                         i, bs_write_req, bs_write_addr, 8'(i));
                miscompares++;
            end
            @(negedge clk);
            #1;
        end
        ld_data_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (ld_data_ready !== 1'b0 || ld_done !== 1'b0 || half_full !== 2'b00) begin
            $display("FAIL rst_mid_state: ready=%b done=%b hf=%b required 0 0 00",
                     ld_data_ready, ld_done, half_full);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (ld_done !== 1'b0 || ld_data_ready !== 1'b0) begin
            $display("FAIL rst_mid_after: done=%b ready=%b required 0 0", ld_done, ld_data_ready);
            miscompares++;
        end
        do_load(4, 8'h51, 8'h00, 2, "post_rst");
        check_half_full(2'b01, "post_rst");
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        ld_start      = 1'b0;
        ld_num_words  = '0;
        ld_data_valid = 1'b0;
        ld_data       = '0;
        rd_start      = 1'b0;
        rd_num_words  = '0;
        rd_stall      = 1'b0;

        test_reset();
        test_load_basic();
        test_read_basic();
        test_full_halves();
        test_park();
        test_stall();
        test_back_to_back();
        test_zero_count();
        test_reset_mid_load();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
